// File: rtl/channel_test_sequencer.sv
// channel_test_sequencer: steps the shared generator/analyzer through
// every channel (settle, generate, analysis window, grade) and builds a
// pass mask and fail count for the host.
// Ports:
//   CLK_100MHz, RESET_N (sync, active-low)
//   start, abort         host controls
//   test_cnt_1/0         P/N edge counts from the analyzer
//   ch_sel               mux channel select
//   enable_generate      generator enable
//   busy, done, aborted  run status
//   pass_mask, fail_count, last_skew  results
module channel_test_sequencer #(
  parameter int N_CH          = 16,
  parameter int CNT_W         = 12,
  parameter int SETTLE_CYCLES = 8,
  parameter int GEN_CYCLES    = 16,
  parameter int WIN_CYCLES    = 1004,
  parameter int MIN_EDGES     = 100,
  parameter int MAX_EDGES     = 4000,
  parameter int MAX_SKEW      = 2
) (
  input  logic             CLK_100MHz,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] test_cnt_1,
  input  logic [CNT_W-1:0] test_cnt_0,
  output logic [3:0]       ch_sel,
  output logic             enable_generate,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [N_CH-1:0]  pass_mask,
  output logic [4:0]       fail_count,
  output logic [CNT_W-1:0] last_skew
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GEN,
    S_ANALYZE,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [15:0] SET_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GEN_LD = 16'(GEN_CYCLES - 1);
  localparam logic [15:0] WIN_LD = 16'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_EDGES);
  localparam logic [CNT_W-1:0] SKEW_C = CNT_W'(MAX_SKEW);
  localparam logic [3:0] LAST_CH = 4'(N_CH - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       ch_q, ch_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abt_q, abt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [4:0]       fail_q, fail_d;
  logic [CNT_W-1:0] skew_q, skew_d;

  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] skew_w;
  logic             ok_w;

  // One extra bit keeps the sign, so |P-N| never wraps.
  always_comb begin
    diff   = {1'b0, test_cnt_1} - {1'b0, test_cnt_0};
    skew_w = diff[CNT_W] ? CNT_W'(-diff) : CNT_W'(diff);
    ok_w   = (test_cnt_1 >= MIN_C) && (test_cnt_1 <= MAX_C) &&
             (test_cnt_0 >= MIN_C) && (test_cnt_0 <= MAX_C) &&
             (skew_w <= SKEW_C);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    fail_d  = fail_q;
    skew_d  = skew_q;
    abt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SETTLE;
          cnt_d   = SET_LD;
          ch_d    = 4'd0;
          mask_d  = '0;
          fail_d  = 5'd0;
          skew_d  = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_GEN;
          cnt_d   = GEN_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GEN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_ANALYZE;
          cnt_d   = WIN_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_ANALYZE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_EVAL: begin
        skew_d = skew_w;
        if (ok_w) begin
          mask_d = mask_q | (N_CH'(1) << ch_q);
        end else begin
          fail_d = fail_q + 5'd1;
        end
        if (ch_q == LAST_CH) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SET_LD;
          ch_d    = ch_q + 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort discards this cycle's grading; done already pulsed in DONE.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ch_d    = ch_q;
      mask_d  = mask_q;
      fail_d  = fail_q;
      skew_d  = skew_q;
      abt_d   = (state_q != S_DONE);
    end
    en_d   = (state_d == S_GEN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      ch_q    <= 4'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      mask_q  <= '0;
      fail_q  <= 5'd0;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      mask_q  <= mask_d;
      fail_q  <= fail_d;
      skew_q  <= skew_d;
    end
  end

  assign ch_sel          = ch_q;
  assign enable_generate = en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = abt_q;
  assign pass_mask       = mask_q;
  assign fail_count      = fail_q;
  assign last_skew       = skew_q;

endmodule

// File: tb/tb_channel_test_sequencer.sv
// tb_channel_test_sequencer: directed bench for the channel sequencer
// with a small 4-channel configuration and a table-driven analyzer.
module tb_channel_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] tc1, tc0;
  logic [3:0]  ch_sel;
  logic        en, busy, done, aborted;
  logic [3:0]  mask;
  logic [4:0]  fcnt;
  logic [11:0] skew;

  logic [11:0] p_tab [4];
  logic [11:0] n_tab [4];

  int checks = 0;
  int errors = 0;

  int d_cyc, e_cnt, f_en, sk2, bad;

  always #5 clk = ~clk;

  // Analyzer stand-in: counts follow the selected channel.
  assign tc1 = p_tab[ch_sel[1:0]];
  assign tc0 = n_tab[ch_sel[1:0]];

  channel_test_sequencer #(
    .N_CH(4), .CNT_W(12), .SETTLE_CYCLES(2), .GEN_CYCLES(4),
    .WIN_CYCLES(20), .MIN_EDGES(10), .MAX_EDGES(100), .MAX_SKEW(2)
  ) dut (
    .CLK_100MHz(clk), .RESET_N(rst_n), .start(start), .abort(abort),
    .test_cnt_1(tc1), .test_cnt_0(tc0), .ch_sel(ch_sel),
    .enable_generate(en), .busy(busy), .done(done),
    .aborted(aborted), .pass_mask(mask), .fail_count(fcnt),
    .last_skew(skew)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_tab(input logic [11:0] p0, n0, p1, n1,
                         p2, n2, p3, n3);
    p_tab[0] = p0; n_tab[0] = n0;
    p_tab[1] = p1; n_tab[1] = n1;
    p_tab[2] = p2; n_tab[2] = n2;
    p_tab[3] = p3; n_tab[3] = n3;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the done
  // cycle (cycle 1 = first SETTLE cycle).
  task automatic run(input bit hold, output int dc, output int ec,
                     output int fe, output int s2, output int bs);
    logic [3:0] pch;
    logic       pen;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    dc = 0; ec = 0; fe = 0; s2 = -1; bs = 0;
    pch = ch_sel; pen = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (en) begin
        ec++;
        if (fe == 0) fe = c;
      end
      if ((en || pen) && ch_sel != pch) bs++;
      if (c == 82) s2 = int'(skew);
      if (done) begin
        dc = c;
        break;
      end
      pch = ch_sel; pen = en;
      @(negedge clk);
    end
    if (dc == 0) chk("run_timeout", 32'd0, 32'd109);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_tab(50, 50, 50, 50, 50, 50, 50, 50);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All channels nominal.
    run(0, d_cyc, e_cnt, f_en, sk2, bad);
    chk("t1_done_cyc", d_cyc, 109);
    chk("t1_en_cnt", e_cnt, 16);
    chk("t1_first_en", f_en, 3);
    chk("t1_sel_stable", bad, 0);
    chk("t1_mask", mask, 4'b1111);
    chk("t1_fail", fcnt, 0);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_after", done, 0);

    // Channel 2 skewed by 3.
    set_tab(50, 50, 50, 50, 50, 53, 50, 50);
    run(0, d_cyc, e_cnt, f_en, sk2, bad);
    chk("t2_mask", mask, 4'b1011);
    chk("t2_fail", fcnt, 1);
    chk("t2_skew_ch2", sk2, 3);
    chk("t2_skew_last", skew, 0);
    @(negedge clk);

    // Range limits.
    set_tab(10, 10, 100, 100, 9, 9, 101, 101);
    run(0, d_cyc, e_cnt, f_en, sk2, bad);
    chk("t3_mask", mask, 4'b0011);
    chk("t3_fail", fcnt, 2);
    @(negedge clk);

    // Extreme counts, no wrap of the difference.
    set_tab(50, 50, 50, 50, 50, 50, 0, 4095);
    run(0, d_cyc, e_cnt, f_en, sk2, bad);
    chk("t4_mask", mask, 4'b0111);
    chk("t4_fail", fcnt, 1);
    chk("t4_skew", skew, 4095);
    @(negedge clk);

    // Abort in channel 1 analysis window (cycle 40).
    set_tab(50, 50, 50, 50, 50, 50, 50, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("t5_pre_ch", ch_sel, 1);
    chk("t5_pre_en", en, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_aborted", aborted, 1);
    chk("t5_done", done, 0);
    chk("t5_mask", mask, 4'b0001);
    chk("t5_en", en, 0);
    @(negedge clk);
    chk("t5_abort_pulse", aborted, 0);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_aborted", aborted, 0);
    @(negedge clk);
    chk("t6_busy2", busy, 0);

    // start held through a full run.
    run(1, d_cyc, e_cnt, f_en, sk2, bad);
    chk("t7_done_cyc", d_cyc, 109);
    chk("t7_en_cnt", e_cnt, 16);
    @(negedge clk);
    chk("t7_idle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("t7_restart", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_abort", aborted, 1);
    @(negedge clk);

    // Reset during channel 1 GEN (cycle 30).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("t8_pre_en", en, 1);
    chk("t8_pre_ch", ch_sel, 1);
    chk("t8_pre_mask", mask, 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_en", en, 0);
    chk("t8_busy", busy, 0);
    chk("t8_ch", ch_sel, 0);
    chk("t8_mask", mask, 0);
    chk("t8_fail", fcnt, 0);
    chk("t8_skew", skew, 0);
    chk("t8_done", done, 0);
    chk("t8_aborted", aborted, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_test_sequencer.md
# channel_test_sequencer

Sequences the edge-count test across all 16 differential channels. One run works through the channels in order. For each channel it selects the channel through the external mux, waits for the path to settle, drives `enable_generate` high for the generate phase, then holds it low for the analysis window. At the end of the window it samples the per-channel P/N edge counts from the signal generator/analyzer and grades them. It sits between the host start/abort controls and the single shared generator/analyzer instance, and builds the pass/fail mask reported to the host.

## Interface
Parameters:
- `N_CH`, 16: number of channels tested per run; 2..16.
- `CNT_W`, 12: width of the analyzer edge counts.
- `SETTLE_CYCLES`, 8: cycles spent after a channel switch before generation starts; ≥1.
- `GEN_CYCLES`, 16: cycles `enable_generate` is held high per channel; ≥1.
- `WIN_CYCLES`, 1004: cycles `enable_generate` is held low per channel. Must be ≥ the analyzer latch point plus 1, so the counts are valid when sampled.
- `MIN_EDGES`, 100: minimum acceptable count on each of P and N, inclusive.
- `MAX_EDGES`, 4000: maximum acceptable count on each of P and N, inclusive.
- `MAX_SKEW`, 2: maximum acceptable |P−N|, inclusive.

Ports:
- `CLK_100MHz`  in  1: the single clock.
- `RESET_N`  in  1: reset, synchronous and active-low.
- `start`  in  1: one-cycle request to begin a run; honoured only in IDLE.
- `abort`  in  1: terminates a run; honoured in any non-IDLE state.
- `test_cnt_1`  in  CNT_W: P edge count from the analyzer.
- `test_cnt_0`  in  CNT_W: N edge count from the analyzer.
- `ch_sel`  out  4: channel select to the mux.
- `enable_generate`  out  1: generator enable; analyzer counts while it is low.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a run completes.
- `aborted`  out  1: one-cycle pulse when a run is aborted.
- `pass_mask`  out  N_CH: bit i = channel i passed in the current or last run.
- `fail_count`  out  5: number of channels that failed in the current or last run.
- `last_skew`  out  CNT_W: |P−N| of the most recently evaluated channel.

## Operation
- States: IDLE, SETTLE, GEN, ANALYZE, EVAL, DONE. One down-counter (16 bit) times the phases; it is reloaded on each phase entry.
- IDLE: `start`=1 and `abort`=0 → SETTLE. On entry to SETTLE: ch_sel=0, pass_mask=0, fail_count=0, last_skew=0.
- SETTLE: lasts SETTLE_CYCLES cycles with enable_generate=0, then → GEN.
- GEN: lasts GEN_CYCLES cycles with enable_generate=1, then → ANALYZE.
- ANALYZE: lasts WIN_CYCLES cycles with enable_generate=0, then → EVAL.
- EVAL: lasts 1 cycle. The block samples test_cnt_1 (P) and test_cnt_0 (N) and grades the channel:
  - The channel passes iff MIN_EDGES ≤ P ≤ MAX_EDGES, MIN_EDGES ≤ N ≤ MAX_EDGES and |P−N| ≤ MAX_SKEW.
  - |P−N| is computed with a CNT_W+1 bit signed difference and then an absolute value, so there is no wrap.
  - On pass, pass_mask[ch_sel] is set. On fail, fail_count is incremented.
  - last_skew is updated in the same cycle.
  - If ch_sel = N_CH−1 → DONE. Otherwise ch_sel is incremented → SETTLE.
- DONE: lasts 1 cycle with done=1, then → IDLE. pass_mask, fail_count and last_skew hold until the next start.
- `abort` in SETTLE, GEN, ANALYZE, EVAL or DONE:
  - Next state is IDLE, with enable_generate=0 and aborted=1 for one cycle.
  - done is not pulsed.
  - pass_mask and fail_count keep the partial results.
  - An EVAL cycle that sees abort does not update the results.
  - abort during DONE suppresses nothing: done has already pulsed in that cycle, and aborted is not raised.
- `start` while busy is ignored. `start`=1 and `abort`=1 together in IDLE: abort wins and the block stays in IDLE.

## Timing
- All outputs are registered. Reset values: ch_sel=0, enable_generate=0, busy=0, done=0, aborted=0, pass_mask=0, fail_count=0, last_skew=0, state=IDLE.
- Reset mid-run returns the block to IDLE on the next edge, with all outputs at their reset values.
- start sampled at edge t → busy=1 and state SETTLE from t+1.
- Per-channel length is SETTLE_CYCLES + GEN_CYCLES + WIN_CYCLES + 1 cycles.
  - enable_generate rises on the first GEN cycle and falls on the first ANALYZE cycle.
- A full run is N_CH × (SETTLE_CYCLES + GEN_CYCLES + WIN_CYCLES + 1) + 1 cycles from the first SETTLE cycle to done.
- busy drops on the cycle after DONE.
- ch_sel changes only on the EVAL→SETTLE transition. ch_sel is never changed while enable_generate=1.
- Inputs are sampled only in EVAL.

## Test plan
Bench parameters: N_CH=4, SETTLE=2, GEN=4, WIN=20, MIN=10, MAX=100, MAX_SKEW=2. Per-channel length is 27 cycles; a full run is 109 cycles.

- Reset then start, counts P=N=50 on every channel → done at cycle 109 after the first SETTLE cycle, pass_mask=4'b1111, fail_count=0, enable_generate high exactly 4 cycles per channel.
- Channel 2 returns P=50, N=53 (others 50/50) → pass_mask=4'b1011, fail_count=1, last_skew=0 after channel 3 (last_skew=3 was visible after channel 2's EVAL).
- Range limits: P=N=10 → pass. P=N=100 → pass. P=N=9 → fail. P=N=101 → fail.
- Extreme values, CNT_W=12: P=0, N=4095 → fail, last_skew=4095 (no wrap).
- abort asserted on cycle 40 (ANALYZE of channel 1) → IDLE next cycle, aborted pulse, done stays 0, pass_mask=4'b0001, enable_generate=0.
- Simultaneous start+abort in IDLE → stays in IDLE, busy=0.
- start held high through a whole run → exactly one run, then a second run starts the cycle after IDLE is re-entered.
- RESET_N low during GEN → all outputs at reset values.
